biquad8_coeff_loader: RTL and testbench
=======================================

// Module: biquad8_coeff_loader
// PURPOSE
//  Single-clock WISHBONE master that programs one biquad8_wrapper_v2 instance out of NCHAN.
//  Programs from a host-filled coefficient table: FIR, pole-FIR, IIR and incremental writes, then optional update.
//  Sits in the WB domain between the control CPU/register bank and the biquad register windows (128 B each).
// PARAMETERS
//  DEPTH     64     table entries (power of 2)
//  NCHAN     16     biquad instances; channel c window base = c*128
//  TIMEOUT   1023   max cycles waiting for wbm_ack_i per transfer (BQLOAD_TIMEOUT_EN only)
// PORTS
//  wb_clk_i    in   1                clock
//  wb_rst_n_i  in   1                asynchronous active-low reset
//  tbl_wr_i    in   1                table write strobe
//  tbl_adr_i   in   $clog2(DEPTH)    table entry index
//  tbl_dat_i   in   23               {reg[6:2] (5b), coeff[17:0]}
//  start_i     in   1                start sequence (1-cycle pulse)
//  chan_i      in   $clog2(NCHAN)    target channel, sampled at start
//  len_i       in   $clog2(DEPTH)+1  entries to send, 0..DEPTH, sampled at start
//  upd_i       in   1                issue update write after last entry, sampled at start
//  busy_o      out  1                sequence in progress
//  done_o      out  1                1-cycle pulse: sequence ended (ok or error)
//  err_o       out  1                sticky: wbm_err_i or timeout seen; cleared by next accepted start
//  wbm_cyc_o   out  1 ; wbm_stb_o out 1 ; wbm_we_o out 1 (always 1 while cyc)
//  wbm_adr_o   out  $clog2(NCHAN)+7  {chan, reg[6:2], 2'b00}
//  wbm_dat_o   out  32               {14'b0, coeff}
//  wbm_sel_o   out  4                4'hF
//  wbm_ack_i   in   1 ; wbm_err_i in 1
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0; table contents undefined (not reset).
//  FSM: IDLE -> FETCH -> WRITE -> (FETCH | UPDATE | DONE) ; UPDATE -> DONE ; DONE -> IDLE.
//  IDLE: start_i accepted -> latch chan/len/upd, clear err_o, idx=0, busy_o=1;
//    len_i==0 -> UPDATE if upd else DONE; len_i>DEPTH clamps to DEPTH.
//  FETCH: one cycle, synchronous table read at idx (1-cycle latency).
//  WRITE: cyc/stb/we=1, adr/dat stable until wbm_ack_i or wbm_err_i.
//    On ack: cyc/stb drop next cycle; idx++; idx==len -> UPDATE (upd) else DONE; else FETCH.
//    Min 2 cycles between successive stb assertions.
//  UPDATE: write adr={chan,7'h00}, dat=32'h1, same handshake.
//  wbm_err_i (any write) -> drop cyc, err_o=1, go DONE (remaining entries skipped).
//  DONE: done_o=1 one cycle, busy_o=0 on the same cycle, -> IDLE.
//  start_i while busy_o: ignored. tbl_wr_i while busy_o: ignored (table frozen during sequence).
//  tbl_wr_i and start_i same cycle in IDLE: write commits; sequence reads new value.
//  ack with stb low: ignored. Async reset mid-transfer drops cyc/stb immediately.
// CONFIGURATION
//  BQLOAD_TIMEOUT_EN defined: per-transfer counter; reaching TIMEOUT cycles with stb high ->
//    cyc/stb drop, err_o=1, DONE. Counter reloads at each stb rise.
//  Undefined: no counter; WRITE/UPDATE wait for ack/err indefinitely; TIMEOUT unused.
// STRUCTURE
//  biquad8_pkg: reg offsets BQ_UPDATE=7'h00, BQ_FIR=7'h04, BQ_IIR=7'h08, BQ_INC=7'h0C,
//    BQ_POLEFIR=7'h10..7'h1C, BQ_WINDOW=128, state enum typedef.
//  Sub-module biquad8_coeff_table: DEPTH x 23 simple dual-port RAM, sync read.
// TESTING
//  1 tbl {04,0x00123},{08,0x3FFFF},{10,0x00001}; start chan=3 len=3 upd=1 -> writes 0x184/0x188/0x190 then 0x180 dat 1, done_o once.
//  2 len=0 upd=1 chan=0 -> single write adr 0x000 dat 1; len=0 upd=0 -> done_o 2 cycles after start, no cyc.
//  3 wbm_err_i on 2nd of 4 writes -> err_o=1, no further stb, done_o; next start clears err_o.
//  4 start_i and tbl_wr_i pulsed mid-sequence -> no effect; sequence matches pre-start table.
//  5 BQLOAD_TIMEOUT_EN, TIMEOUT=15, ack never -> stb drops on 15th cycle, err_o=1; without macro stb held.
//  6 ack delayed 0..20 cycles randomised (emulating CDC ack) -> adr/dat stable while stb high, order preserved.

Source files
------------

// File: rtl/biquad8_pkg.sv
// Shared definitions for the biquad8 coefficient loader: register offsets inside one
// biquad8_wrapper_v2 window, the table entry layout and the loader FSM states.
package biquad8_pkg;

   localparam logic [6:0] BQ_UPDATE  = 7'h00;
   localparam logic [6:0] BQ_FIR     = 7'h04;
   localparam logic [6:0] BQ_IIR     = 7'h08;
   localparam logic [6:0] BQ_INC     = 7'h0C;
   localparam logic [6:0] BQ_POLEFIR = 7'h10;   // four consecutive words, 7'h10..7'h1C
   localparam int unsigned BQ_WINDOW = 128;
   localparam int unsigned BQ_TBL_W  = 23;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WRITE,
      ST_UPDATE,
      ST_DONE
   } bq_state_t;

   typedef struct packed {
      logic [4:0]  reg_sel;
      logic [17:0] coeff;
   } bq_entry_t;

   function automatic logic [31:0] bq_data(input logic [17:0] coeff);
      return {14'b0, coeff};
   endfunction

endpackage

// File: rtl/biquad8_coeff_loader_if.sv
// WISHBONE master bus between the coefficient loader and the biquad register windows.
// AW must equal $clog2(NCHAN)+7 of the loader it is attached to.
interface biquad8_coeff_loader_if #(
   parameter int AW = 11
);
   logic          wbm_cyc_o;
   logic          wbm_stb_o;
   logic          wbm_we_o;
   logic [AW-1:0] wbm_adr_o;
   logic [31:0]   wbm_dat_o;
   logic [3:0]    wbm_sel_o;
   logic          wbm_ack_i;
   logic          wbm_err_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
      input  wbm_ack_i, wbm_err_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
      output wbm_ack_i, wbm_err_i
   );
endinterface

// File: rtl/biquad8_coeff_table.sv
// DEPTH x W simple dual-port coefficient table: one write port, one registered read port.
// Contents are not reset; the read register only updates when i_rd_en is high.
module biquad8_coeff_table #(
   parameter  int DEPTH = 64,
   parameter  int W     = 23,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_wr_en,
   input  logic [AW-1:0] i_wr_adr,
   input  logic [W-1:0]  i_wr_dat,
   input  logic          i_rd_en,
   input  logic [AW-1:0] i_rd_adr,
   output logic [W-1:0]  o_rd_dat
);

   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_rd_dat;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_adr] <= i_wr_dat;
      end
      if (i_rd_en) begin
         r_rd_dat <= r_mem[i_rd_adr];
      end
   end

   assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/biquad8_coeff_loader.sv
// WISHBONE master that streams a host-filled coefficient table into one biquad8 window,
// optionally followed by an update write. Define BQLOAD_TIMEOUT_EN for a per-transfer ack timeout.
module biquad8_coeff_loader
   import biquad8_pkg::*;
#(
   parameter  int DEPTH   = 64,
   parameter  int NCHAN   = 16
`ifdef BQLOAD_TIMEOUT_EN
   ,
   parameter  int TIMEOUT = 1023
`endif
   ,
   localparam int TW      = $clog2(DEPTH),
   localparam int CW      = $clog2(NCHAN)
) (
   input  logic                          wb_clk_i,
   input  logic                          wb_rst_n_i,
   input  logic                          tbl_wr_i,
   input  logic [TW-1:0]                 tbl_adr_i,
   input  logic [22:0]                   tbl_dat_i,
   input  logic                          start_i,
   input  logic [CW-1:0]                 chan_i,
   input  logic [TW:0]                   len_i,
   input  logic                          upd_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o,
   biquad8_coeff_loader_if.master        wbm
);

   bq_state_t     r_state;
   logic [CW-1:0] r_chan;
   logic [TW:0]   r_len;
   logic [TW:0]   r_idx;
   logic          r_upd;
   logic          r_busy;
   logic          r_done;
   logic          r_err;
   logic          r_cyc;
   logic          r_stb;

   logic [22:0]   w_rd_dat;
   bq_entry_t     w_rd;
   logic [TW:0]   w_len_clamped;
   logic [TW:0]   w_idx_inc;
   logic          w_ack;
   logic          w_err;
   logic          w_tmo_hit;
   logic          w_fail;
   logic          w_is_upd;

   // The table is frozen while a sequence runs so the host cannot race the reader.
   biquad8_coeff_table #(
      .DEPTH (DEPTH),
      .W     (BQ_TBL_W)
   ) u_table (
      .i_clk    (wb_clk_i),
      .i_wr_en  (tbl_wr_i & ~r_busy),
      .i_wr_adr (tbl_adr_i),
      .i_wr_dat (tbl_dat_i),
      .i_rd_en  (r_state == ST_FETCH),
      .i_rd_adr (r_idx[TW-1:0]),
      .o_rd_dat (w_rd_dat)
   );

   assign w_rd          = bq_entry_t'(w_rd_dat);
   assign w_len_clamped = (len_i > (TW+1)'(DEPTH)) ? (TW+1)'(DEPTH) : len_i;
   assign w_idx_inc     = r_idx + (TW+1)'(1);
   assign w_ack         = r_stb & wbm.wbm_ack_i;
   assign w_err         = r_stb & wbm.wbm_err_i;
   assign w_fail        = w_err | (w_tmo_hit & ~wbm.wbm_ack_i);

`ifdef BQLOAD_TIMEOUT_EN
   localparam int MW = $clog2(TIMEOUT + 1);
   logic [MW-1:0] r_tmo;

   // stb is always low for at least one cycle between transfers, so clearing while low reloads per rise.
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         r_tmo <= '0;
      end else if (!r_stb) begin
         r_tmo <= '0;
      end else begin
         r_tmo <= r_tmo + MW'(1);
      end
   end

   assign w_tmo_hit = r_stb & (r_tmo == MW'(TIMEOUT - 1));
`else
   assign w_tmo_hit = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         r_state <= ST_IDLE;
         r_chan  <= '0;
         r_len   <= '0;
         r_idx   <= '0;
         r_upd   <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_cyc   <= 1'b0;
         r_stb   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  r_chan <= chan_i;
                  r_len  <= w_len_clamped;
                  r_upd  <= upd_i;
                  r_idx  <= '0;
                  r_err  <= 1'b0;
                  r_busy <= 1'b1;
                  if (len_i == '0) begin
                     r_state <= upd_i ? ST_UPDATE : ST_DONE;
                  end else begin
                     r_state <= ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               r_cyc   <= 1'b1;
               r_stb   <= 1'b1;
               r_state <= ST_WRITE;
            end
            ST_WRITE: begin
               if (w_fail) begin
                  r_cyc   <= 1'b0;
                  r_stb   <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= ST_DONE;
               end else if (w_ack) begin
                  r_cyc <= 1'b0;
                  r_stb <= 1'b0;
                  r_idx <= w_idx_inc;
                  if (w_idx_inc == r_len) begin
                     r_state <= r_upd ? ST_UPDATE : ST_DONE;
                  end else begin
                     r_state <= ST_FETCH;
                  end
               end
            end
            ST_UPDATE: begin
               // Entered with stb low, so the update strobe starts one cycle later.
               if (!r_stb) begin
                  r_cyc <= 1'b1;
                  r_stb <= 1'b1;
               end else if (w_fail) begin
                  r_cyc   <= 1'b0;
                  r_stb   <= 1'b0;
                  r_err   <= 1'b1;
                  r_state <= ST_DONE;
               end else if (w_ack) begin
                  r_cyc   <= 1'b0;
                  r_stb   <= 1'b0;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_cyc   <= 1'b0;
               r_stb   <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Address/data come straight from registers; the table read register only moves in FETCH.
   assign w_is_upd      = (r_state == ST_UPDATE);
   assign wbm.wbm_cyc_o = r_cyc;
   assign wbm.wbm_stb_o = r_stb;
   assign wbm.wbm_we_o  = r_cyc;
   assign wbm.wbm_sel_o = r_cyc ? 4'hF : 4'h0;
   assign wbm.wbm_adr_o = !r_cyc   ? '0 :
                          w_is_upd ? {r_chan, BQ_UPDATE} :
                                     {r_chan, w_rd.reg_sel, 2'b00};
   assign wbm.wbm_dat_o = !r_cyc   ? 32'h0 :
                          w_is_upd ? 32'h1 :
                                     bq_data(w_rd.coeff);

   assign busy_o = r_busy;
   assign done_o = r_done;
   assign err_o  = r_err;

endmodule

// File: tb/tb_biquad8_coeff_loader.sv
// Directed bench for biquad8_coeff_loader (default build): a WISHBONE slave model logs every
// write, and each sequence is compared against hand-computed addresses and data.
module tb_biquad8_coeff_loader;
   import biquad8_pkg::*;

   localparam int DEPTH = 64;
   localparam int NCHAN = 16;
   localparam int TW    = 6;
   localparam int CW    = 4;
   localparam int AW    = 11;

   logic          clk     = 1'b0;
   logic          rst_n   = 1'b0;
   logic          tbl_wr  = 1'b0;
   logic [TW-1:0] tbl_adr = '0;
   logic [22:0]   tbl_dat = '0;
   logic          start   = 1'b0;
   logic [CW-1:0] chan    = '0;
   logic [TW:0]   len     = '0;
   logic          upd     = 1'b0;
   logic          busy;
   logic          done;
   logic          err;

   biquad8_coeff_loader_if #(.AW(AW)) wb ();

   biquad8_coeff_loader #(
      .DEPTH (DEPTH),
      .NCHAN (NCHAN)
   ) dut (
      .wb_clk_i   (clk),
      .wb_rst_n_i (rst_n),
      .tbl_wr_i   (tbl_wr),
      .tbl_adr_i  (tbl_adr),
      .tbl_dat_i  (tbl_dat),
      .start_i    (start),
      .chan_i     (chan),
      .len_i      (len),
      .upd_i      (upd),
      .busy_o     (busy),
      .done_o     (done),
      .err_o      (err),
      .wbm        (wb.master)
   );

   always #5 clk = ~clk;

   int n_cmp      = 0;
   int n_bad      = 0;
   int done_cnt   = 0;
   int proto_bad  = 0;
   int xfer_cnt   = 0;
   int err_at     = -1;
   int fixed_dly  = 0;
   bit rand_dly   = 1'b0;
   bit hold       = 1'b0;
   int log_adr[$];
   int log_dat[$];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_log(input int k, input int adr, input int dat, input string tag);
      if (k < log_adr.size()) begin
         check_val({tag, "_adr"}, 64'(log_adr[k]), 64'(adr));
         check_val({tag, "_dat"}, 64'(log_dat[k]), 64'(dat));
      end else begin
         check_val({tag, "_present"}, 64'(log_adr.size()), 64'(k + 1));
      end
   endtask

   always @(negedge clk) begin
      if (done) done_cnt++;
   end

   // Slave: logs each transfer at stb rise, checks adr/dat stay put, answers after a delay.
   initial begin : wb_slave
      int          wait_left;
      logic [31:0] cur_adr;
      logic [31:0] cur_dat;
      bit          in_xfer;
      wb.wbm_ack_i = 1'b0;
      wb.wbm_err_i = 1'b0;
      wait_left    = 0;
      cur_adr      = '0;
      cur_dat      = '0;
      in_xfer      = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (wb.wbm_ack_i || wb.wbm_err_i) begin
            wb.wbm_ack_i = 1'b0;
            wb.wbm_err_i = 1'b0;
            in_xfer      = 1'b0;
            if (wb.wbm_stb_o) proto_bad++;
         end else if (wb.wbm_cyc_o && wb.wbm_stb_o) begin
            if (!in_xfer) begin
               in_xfer = 1'b1;
               cur_adr = 32'(wb.wbm_adr_o);
               cur_dat = wb.wbm_dat_o;
               log_adr.push_back(int'(cur_adr));
               log_dat.push_back(int'(cur_dat));
               wait_left = rand_dly ? int'($urandom_range(0, 20)) : fixed_dly;
               if (!wb.wbm_we_o || wb.wbm_sel_o != 4'hF) proto_bad++;
               $display("wb write %0d: adr=%03h dat=%08h", xfer_cnt, cur_adr, cur_dat);
            end else if (32'(wb.wbm_adr_o) != cur_adr || wb.wbm_dat_o != cur_dat) begin
               proto_bad++;
            end
            if (!hold) begin
               if (wait_left == 0) begin
                  if (xfer_cnt == err_at) wb.wbm_err_i = 1'b1;
                  else                    wb.wbm_ack_i = 1'b1;
                  xfer_cnt++;
               end else begin
                  wait_left--;
               end
            end
         end else begin
            in_xfer = 1'b0;
         end
      end
   end

   task automatic tbl_write(input int idx, input logic [6:0] reg7, input logic [17:0] coeff);
      @(posedge clk); #1;
      tbl_wr  = 1'b1;
      tbl_adr = TW'(idx);
      tbl_dat = {reg7[6:2], coeff};
      @(posedge clk); #1;
      tbl_wr  = 1'b0;
   endtask

   task automatic run_seq(input int c, input int l, input bit u, input bit disturb, input string tag);
      int d0;
      bit seen;
      d0 = done_cnt;
      log_adr.delete();
      log_dat.delete();
      @(posedge clk); #1;
      start = 1'b1;
      chan  = CW'(c);
      len   = (TW+1)'(l);
      upd   = u;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_val({tag, "_busy"}, 64'(busy), 64'd1);
      if (disturb) begin
         @(posedge clk); #1;
         start   = 1'b1;
         chan    = 4'd7;
         len     = 7'd1;
         upd     = 1'b1;
         tbl_wr  = 1'b1;
         tbl_adr = 6'd3;
         tbl_dat = 23'h7FFFFF;
         @(posedge clk); #1;
         start   = 1'b0;
         tbl_wr  = 1'b0;
      end
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (done_cnt != d0) seen = 1'b1;
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: got no done_o within 3000 cycles, required one", tag);
      end
      repeat (3) @(negedge clk);
      check_val({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int d0;
      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_busy", 64'(busy), 64'd0);
      check_val("rst_done", 64'(done), 64'd0);
      check_val("rst_err",  64'(err),  64'd0);
      check_val("rst_cyc",  64'(wb.wbm_cyc_o), 64'd0);
      check_val("rst_stb",  64'(wb.wbm_stb_o), 64'd0);
      check_val("rst_adr",  64'(wb.wbm_adr_o), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 1: FIR/IIR/pole-FIR entries on channel 3, then update
      tbl_write(0, BQ_FIR,     18'h00123);
      tbl_write(1, BQ_IIR,     18'h3FFFF);
      tbl_write(2, BQ_POLEFIR, 18'h00001);
      run_seq(3, 3, 1'b1, 1'b0, "t1");
      check_val("t1_count", 64'(log_adr.size()), 64'd4);
      check_log(0, 'h184, 'h00123, "t1_w0");
      check_log(1, 'h188, 'h3FFFF, "t1_w1");
      check_log(2, 'h190, 'h00001, "t1_w2");
      check_log(3, 'h180, 'h1,     "t1_upd");
      check_val("t1_err", 64'(err), 64'd0);

      // 2a: empty table with update on channel 0
      run_seq(0, 0, 1'b1, 1'b0, "t2a");
      check_val("t2a_count", 64'(log_adr.size()), 64'd1);
      check_log(0, 'h000, 'h1, "t2a_upd");

      // 2b: empty, no update: done_o two cycles after start, no bus cycle
      log_adr.delete();
      log_dat.delete();
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; chan = 4'd0; len = 7'd0; upd = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check_val("t2b_done_c1", 64'(done), 64'd0);
      check_val("t2b_busy_c1", 64'(busy), 64'd1);
      @(negedge clk);
      check_val("t2b_done_c2", 64'(done), 64'd1);
      check_val("t2b_busy_c2", 64'(busy), 64'd0);
      @(negedge clk);
      check_val("t2b_done_c3", 64'(done), 64'd0);
      check_val("t2b_done_cnt", 64'(done_cnt - d0), 64'd1);
      check_val("t2b_count", 64'(log_adr.size()), 64'd0);

      // 3: bus error on the 2nd of 4 writes
      tbl_write(0, 7'h10, 18'h00011);
      tbl_write(1, 7'h14, 18'h00022);
      tbl_write(2, 7'h18, 18'h00033);
      tbl_write(3, 7'h1C, 18'h00044);
      xfer_cnt = 0;
      err_at   = 1;
      run_seq(5, 4, 1'b1, 1'b0, "t3");
      err_at   = -1;
      check_val("t3_err", 64'(err), 64'd1);
      check_val("t3_count", 64'(log_adr.size()), 64'd2);
      check_log(0, 'h290, 'h11, "t3_w0");
      check_log(1, 'h294, 'h22, "t3_w1");
      run_seq(0, 0, 1'b0, 1'b0, "t3_clr");
      check_val("t3_err_cleared", 64'(err), 64'd0);

      // 4: start/table write during a sequence are ignored
      fixed_dly = 3;
      run_seq(1, 4, 1'b0, 1'b1, "t4");
      fixed_dly = 0;
      check_val("t4_count", 64'(log_adr.size()), 64'd4);
      check_log(0, 'h090, 'h11, "t4_w0");
      check_log(1, 'h094, 'h22, "t4_w1");
      check_log(2, 'h098, 'h33, "t4_w2");
      check_log(3, 'h09C, 'h44, "t4_w3");

      // 5: no timeout in default build: stb held while ack withheld
      hold = 1'b1;
      log_adr.delete();
      log_dat.delete();
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; chan = 4'd2; len = 7'd0; upd = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (40) @(negedge clk);
      check_val("t5_stb_held", 64'(wb.wbm_stb_o), 64'd1);
      check_val("t5_busy", 64'(busy), 64'd1);
      check_val("t5_adr", 64'(wb.wbm_adr_o), 64'h100);
      hold = 1'b0;
      repeat (6) @(negedge clk);
      check_val("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
      check_val("t5_err", 64'(err), 64'd0);

      // 6: randomised ack latency, 8 entries plus update on channel 9
      for (int i = 0; i < 8; i++) begin
         tbl_write(i, 7'((i + 1) * 4), 18'(18'h01000 + i * 18'h00111));
      end
      rand_dly = 1'b1;
      run_seq(9, 8, 1'b1, 1'b0, "t6");
      rand_dly = 1'b0;
      check_val("t6_count", 64'(log_adr.size()), 64'd9);
      for (int i = 0; i < 8; i++) begin
         check_log(i, 'h480 + (i + 1) * 4, 'h01000 + i * 'h111, $sformatf("t6_w%0d", i));
      end
      check_log(8, 'h480, 'h1, "t6_upd");
      check_val("t6_protocol", 64'(proto_bad), 64'd0);

      // 7: table write and start in the same idle cycle: sequence sees the new entry
      log_adr.delete();
      log_dat.delete();
      d0 = done_cnt;
      @(posedge clk); #1;
      tbl_wr = 1'b1; tbl_adr = 6'd0; tbl_dat = {BQ_INC[6:2], 18'h2AAAA};
      start  = 1'b1; chan = 4'd15; len = 7'd1; upd = 1'b0;
      @(posedge clk); #1;
      tbl_wr = 1'b0;
      start  = 1'b0;
      repeat (10) @(negedge clk);
      check_val("t7_done_cnt", 64'(done_cnt - d0), 64'd1);
      check_val("t7_count", 64'(log_adr.size()), 64'd1);
      check_log(0, 'h78C, 'h2AAAA, "t7_w0");

      // 8: len above DEPTH clamps to DEPTH writes
      run_seq(0, 100, 1'b0, 1'b0, "t8");
      check_val("t8_count", 64'(log_adr.size()), 64'd64);
      check_val("t8_busy", 64'(busy), 64'd0);

      check_val("protocol_total", 64'(proto_bad), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
